// File: rtl/alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU issue sequencer: ALU op encodings, FSM state
// encodings, default sizing and a saturating 32-bit increment helper used by
// the optional performance counters (ALU_SEQ_PERF_EN).
// -----------------------------------------------------------------------------
package alu_sequencer_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MUL_LATENCY = 8;

  // Request / ALU op encodings. 2'b11 is never forwarded to the ALU.
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_MUL = 2'b10;
  localparam logic [1:0] ALU_OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXEC     = 2'b01,
    ST_MUL_WAIT = 2'b10,
    ST_RESP     = 2'b11
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/alu_latency_counter.sv
// -----------------------------------------------------------------------------
// alu_latency_counter
// Load/decrement down-counter timing the multiplier latency.
//   clk, reset : clock, asynchronous active-high reset (count cleared to 0)
//   load_i     : load MUL_LATENCY-1 (takes priority over dec_i)
//   dec_i      : decrement by one, holding at zero
//   done_o     : count is zero
// -----------------------------------------------------------------------------
module alu_latency_counter #(
  parameter int MUL_LATENCY = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int            CW       = $clog2(MUL_LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load wins, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Issue controller between decode/issue and the single execution-stage ALU.
// Accepts one request at a time, drives the ALU only from registered operands,
// waits out the multiplier latency, and returns the captured result.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/ready     : request handshake; req_op/req_a/req_b payload
//   resp_valid/ready    : response handshake; resp_result/zero/error payload
//   alu_op/first/second : ALU controls; mul_start one-cycle multiplier start
//   alu_result          : ALU result (low WIDTH bits of product for mul)
//   busy                : sequencer not idle
// Optional (macro ALU_SEQ_PERF_EN): perf_ops, perf_mul_cycles saturating
// counters of completed responses and cycles spent in MUL_WAIT.
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_error,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_first,
  output logic [WIDTH-1:0] alu_second,
  output logic             mul_start,
  input  logic [WIDTH-1:0] alu_result,
`ifdef ALU_SEQ_PERF_EN
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_mul_cycles,
`endif
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             error_q, error_d;
  logic             resp_valid_q, resp_valid_d;
  logic             mul_start_q, mul_start_d;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             cnt_done_s;

  alu_latency_counter #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_lat_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load_s),
    .dec_i  (cnt_dec_s),
    .done_o (cnt_done_s)
  );

  // Next-state and next-register values for the whole sequencer.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    first_d      = first_q;
    second_d     = second_q;
    result_d     = result_q;
    zero_d       = zero_q;
    error_d      = error_q;
    resp_valid_d = resp_valid_q;
    mul_start_d  = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_dec_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          error_d = 1'b0;
          case (req_op)
            ALU_OP_ADD: begin
              state_d  = ST_EXEC;
              op_d     = ALU_OP_ADD;
              first_d  = req_a;
              second_d = req_b;
            end
            ALU_OP_SUB: begin
              // The ALU adder has no carry-in, so negate b here.
              state_d  = ST_EXEC;
              op_d     = ALU_OP_SUB;
              first_d  = req_a;
              second_d = ~req_b + ONE_W;
            end
            ALU_OP_MUL: begin
              state_d     = ST_MUL_WAIT;
              op_d        = ALU_OP_MUL;
              first_d     = req_a;
              second_d    = req_b;
              mul_start_d = 1'b1;
              cnt_load_s  = 1'b1;
            end
            default: begin
              // Illegal op: answer immediately, ALU stays untouched.
              state_d      = ST_RESP;
              result_d     = '0;
              zero_d       = 1'b1;
              error_d      = 1'b1;
              resp_valid_d = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d      = ST_RESP;
        result_d     = alu_result;
        zero_d       = (alu_result == '0);
        resp_valid_d = 1'b1;
        op_d         = ALU_OP_ADD;
        first_d      = '0;
        second_d     = '0;
      end
      ST_MUL_WAIT: begin
        if (cnt_done_s) begin
          state_d      = ST_RESP;
          result_d     = alu_result;
          zero_d       = (alu_result == '0);
          resp_valid_d = 1'b1;
          op_d         = ALU_OP_ADD;
          first_d      = '0;
          second_d     = '0;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= ALU_OP_ADD;
      first_q      <= '0;
      second_q     <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      error_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      mul_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      first_q      <= first_d;
      second_q     <= second_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      error_q      <= error_d;
      resp_valid_q <= resp_valid_d;
      mul_start_q  <= mul_start_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_error  = error_q;
  assign alu_op      = op_q;
  assign alu_first   = first_q;
  assign alu_second  = second_q;
  assign mul_start   = mul_start_q;

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_mul_q;

  // Saturating counters of completed responses and multiplier wait cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops_q <= 32'd0;
      perf_mul_q <= 32'd0;
    end else begin
      if (resp_valid_q && resp_ready) begin
        perf_ops_q <= sat_inc32(perf_ops_q);
      end
      if (state_q == ST_MUL_WAIT) begin
        perf_mul_q <= sat_inc32(perf_mul_q);
      end
    end
  end

  assign perf_ops        = perf_ops_q;
  assign perf_mul_cycles = perf_mul_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int W  = 32;
  localparam int ML = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_result;
  logic         resp_zero;
  logic         resp_error;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_first;
  logic [W-1:0] alu_second;
  logic         mul_start;
  logic [W-1:0] alu_result;
  logic         busy;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0]  perf_ops;
  logic [31:0]  perf_mul_cycles;
`endif

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_error  (resp_error),
    .alu_op      (alu_op),
    .alu_first   (alu_first),
    .alu_second  (alu_second),
    .mul_start   (mul_start),
    .alu_result  (alu_result),
`ifdef ALU_SEQ_PERF_EN
    .perf_ops        (perf_ops),
    .perf_mul_cycles (perf_mul_cycles),
`endif
    .busy        (busy)
  );

  // ALU model: adder is combinational; multiplier product becomes valid only
  // MUL_LATENCY-1 cycles after the start cycle, garbage before that.
  int          mul_age;
  logic [63:0] prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mul_age <= 0;
    else if (mul_start) mul_age <= 1;
    else if (alu_op != 2'b10) mul_age <= 0;
    else if (mul_age != 0 && mul_age < 1000) mul_age <= mul_age + 1;
  end

  always_comb begin
    prod = {32'd0, alu_first} * {32'd0, alu_second};
    if (alu_op == 2'b10) alu_result = (mul_age >= ML - 1) ? prod[W-1:0] : 32'hBAD0_BAD0;
    else alu_result = alu_first + alu_second;
  end

  // Scoreboard
  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         error;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         e;
  } vec_t;
  vec_t vecs[9];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},   req_ready,   1);
    chk({tag, "_resp_valid"},  resp_valid,  0);
    chk({tag, "_resp_result"}, resp_result, 0);
    chk({tag, "_resp_zero"},   resp_zero,   0);
    chk({tag, "_resp_error"},  resp_error,  0);
    chk({tag, "_mul_start"},   mul_start,   0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_alu_op"},      alu_op,      0);
    chk({tag, "_alu_first"},   alu_first,   0);
    chk({tag, "_alu_second"},  alu_second,  0);
  endtask

  // One full transaction; hold>0 keeps resp_ready low for that many cycles
  // after the response appears.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ez, input logic ee, input int hold);
    int           lat_exp;
    int           cyc;
    int           starts;
    int           start_cyc;
    bit           done;
    logic [W-1:0] exp_sec;
    exp_t         e;
    exp_t         got;
    lat_exp = (op == 2'b10) ? ML + 1 : ((op == 2'b11) ? 1 : 2);
    exp_sec = (op == 2'b01) ? (~b + 32'd1) : b;
    resp_ready = (hold == 0);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    e.result = er; e.zero = ez; e.error = ee;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'(op + 2'd1);
    cyc = 0; starts = 0; start_cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (mul_start) begin starts++; start_cyc = cyc; end
      if (resp_valid || cyc > 40) done = 1;
      else begin
        chk("alu_op_held", alu_op, op);
        chk("alu_first_held", alu_first, a);
        chk("alu_second_held", alu_second, exp_sec);
        chk("req_ready_busy", req_ready, 0);
      end
    end
    chk("latency", cyc, lat_exp);
    chk("mul_start_count", starts, (op == 2'b10) ? 1 : 0);
    if (op == 2'b10) chk("mul_start_cycle", start_cyc, 1);
    if (resp_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty: got response %0h expected none", resp_result);
      end else begin
        got = sb.pop_front();
        chk("result", resp_result, got.result);
        chk("zero", resp_zero, got.zero);
        chk("error", resp_error, got.error);
      end
      chk("alu_op_resp", alu_op, 0);
      chk("alu_first_resp", alu_first, 0);
      chk("alu_second_resp", alu_second, 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_resp_valid", resp_valid, 1);
        chk("bp_result", resp_result, er);
        chk("bp_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_hs_resp_valid", resp_valid, 0);
      chk("post_hs_req_ready", req_ready, 1);
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; resp_ready = 1'b1;
    vecs[0] = '{2'b00, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vecs[1] = '{2'b01, 32'd3,          32'd3,          32'd0,          1'b1, 1'b0};
    vecs[2] = '{2'b01, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[3] = '{2'b10, 32'd6,          32'd7,          32'd42,         1'b0, 1'b0};
    vecs[4] = '{2'b11, 32'd9,          32'd9,          32'd0,          1'b1, 1'b1};
    vecs[5] = '{2'b00, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
    vecs[6] = '{2'b10, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 1'b0};
    vecs[7] = '{2'b01, 32'd10,         32'd3,          32'd7,          1'b0, 1'b0};
    vecs[8] = '{2'b10, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].e, 0);
    end

    // Backpressure: response held for 5 cycles
    run_op(2'b00, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 5);

    // Reset in the middle of a multiply drops it
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'd6; req_b = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_mul_busy", busy, 1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("mid_mul_reset");
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b00, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 0);

`ifdef ALU_SEQ_PERF_EN
    chk("perf_ops", perf_ops, 1);
    chk("perf_mul_cycles", perf_mul_cycles, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
